// File: rtl/fifo_bus_master.sv
// Single-port FIFO bus master: arbitrates user write/read requests onto a shared
// tristate bus, round-robin, with one turnaround cycle whenever direction changes.
//
// state | meaning
// IDLE  | no bus activity this cycle
// WRITE | write issued, bus driven with WR_DATA
// READ  | read issued, FIFO pops and drives the bus next cycle
// TURN  | bus turnaround before a direction change, nothing driven
module fifo_bus_master #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  inout  wire  [N-1:0]  INOUT,
  output logic          EN,
  output logic          READ_WRITE,
  input  logic          FULL,
  input  logic          EMPTY,
  input  logic          WR_REQ,
  input  logic [N-1:0]  WR_DATA,
  output logic          WR_ACK,
  input  logic          RD_REQ,
  output logic          RD_ACK,
  output logic          RD_VALID,
  output logic [N-1:0]  RD_DATA,
  output logic [CW-1:0] TX_COUNT,
  output logic [CW-1:0] RX_COUNT,
  output logic          BUSY
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  // state_nxt is the state of the current cycle, decided from this cycle's
  // requests and flags; state remembers it so a TURN is followed by its own op.
  state_t state, state_nxt;
  logic   dir;
  logic   rw_q;
  logic   cap_pend;
  logic   wr_legal, rd_legal;
  logic   want_wr, want_any;

  assign wr_legal = WR_REQ & ~FULL;
  assign rd_legal = RD_REQ & ~EMPTY;

  always_comb begin
    want_wr   = dir;
    want_any  = RESET & (wr_legal | rd_legal);
    state_nxt = IDLE;
    if (state == TURN && (dir ? wr_legal : rd_legal))
      want_wr = dir;
    else if (wr_legal && rd_legal)
      want_wr = ~dir;
    else
      want_wr = wr_legal;
    if (want_any) begin
      if (want_wr != dir)
        state_nxt = TURN;
      else if (want_wr)
        state_nxt = WRITE;
      else
        state_nxt = READ;
    end
  end

  assign EN         = (state_nxt == WRITE) || (state_nxt == READ);
  assign READ_WRITE = (state_nxt == WRITE) ? 1'b1 :
                      (state_nxt == READ)  ? 1'b0 : rw_q;
  assign WR_ACK     = (state_nxt == WRITE);
  assign RD_ACK     = (state_nxt == READ);
  assign BUSY       = (state_nxt != IDLE) || cap_pend;
  assign INOUT      = (state_nxt == WRITE) ? WR_DATA : {N{1'bz}};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      dir      <= 1'b1;
      rw_q     <= 1'b1;
      cap_pend <= 1'b0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      TX_COUNT <= '0;
      RX_COUNT <= '0;
    end else begin
      state    <= state_nxt;
      cap_pend <= (state_nxt == READ);
      RD_VALID <= cap_pend;
      if (state_nxt == TURN)
        dir <= ~dir;
      if (state_nxt == WRITE) begin
        rw_q     <= 1'b1;
        TX_COUNT <= TX_COUNT + 1'b1;
      end
      if (state_nxt == READ)
        rw_q <= 1'b0;
      // FIFO drives the popped word during the cycle after the read issue
      if (cap_pend) begin
        RD_DATA  <= INOUT;
        RX_COUNT <= RX_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_bus_master.sv
// Self-checking bench for fifo_bus_master: FIFO responder on the shared bus plus a
// transaction-level model of arbitration, turnaround and read capture.
module tb_fifo_bus_master;
  localparam int N  = 8;
  localparam int CW = 16;
  localparam int A_IDLE = 0, A_WR = 1, A_RD = 2, A_TURN = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  wire  [N-1:0]  bus;
  logic          en, rw, wr_ack, rd_ack, rd_valid, busy;
  logic          full = 1'b0, empty = 1'b1, wr_req = 1'b0, rd_req = 1'b0;
  logic [N-1:0]  wr_data = '0;
  logic [N-1:0]  rd_data;
  logic [CW-1:0] tx_count, rx_count;

  logic          env_oe = 1'b0, probe_oe = 1'b0;
  logic [N-1:0]  env_val = '0, probe_val = '0;
  assign bus = env_oe ? env_val : (probe_oe ? probe_val : {N{1'bz}});

  int tests = 0;
  int fails = 0;

  fifo_bus_master #(.N(N), .CW(CW)) dut (
    .CLK(clk), .RESET(rst_n), .INOUT(bus), .EN(en), .READ_WRITE(rw),
    .FULL(full), .EMPTY(empty), .WR_REQ(wr_req), .WR_DATA(wr_data), .WR_ACK(wr_ack),
    .RD_REQ(rd_req), .RD_ACK(rd_ack), .RD_VALID(rd_valid), .RD_DATA(rd_data),
    .TX_COUNT(tx_count), .RX_COUNT(rx_count), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // FIFO responder: pops drive the bus for one cycle after the issue edge.
  logic [N-1:0] fifo_q[$];
  logic         pop_now = 1'b0, push_now = 1'b0;
  logic [N-1:0] push_val = '0;

  always @(negedge clk) begin
    pop_now  = en & ~rw;
    push_now = en & rw;
    push_val = bus;
  end

  always @(posedge clk) begin
    #1;
    env_oe = 1'b0;
    if (pop_now) begin
      env_val = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
      env_oe  = 1'b1;
    end
    if (push_now) fifo_q.push_back(push_val);
    pop_now  = 1'b0;
    push_now = 1'b0;
  end

  // Reference model: what the master does this cycle and what it has done so far.
  int           m_act;
  bit           m_dir, m_after_turn, m_rw, m_cap_pend, m_valid;
  logic [N-1:0] m_cap_data, m_rd_data, m_issue_data;
  int unsigned  m_tx, m_rx;

  task automatic model_reset();
    m_act = A_IDLE; m_dir = 1'b1; m_after_turn = 1'b0; m_rw = 1'b1;
    m_cap_pend = 1'b0; m_valid = 1'b0; m_cap_data = '0; m_rd_data = '0;
    m_issue_data = '0; m_tx = 0; m_rx = 0;
  endtask

  task automatic model_eval();
    bit wl, rl, want;
    wl = wr_req && !full;
    rl = rd_req && !empty;
    if (!wl && !rl) m_act = A_IDLE;
    else begin
      // a direction chosen at a turn is served next if still wanted
      if (m_after_turn && (m_dir ? wl : rl)) want = m_dir;
      else if (wl && rl) want = !m_dir;
      else want = wl;
      if (want != m_dir) m_act = A_TURN;
      else m_act = want ? A_WR : A_RD;
    end
    m_issue_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic model_commit();
    m_valid = m_cap_pend;
    if (m_cap_pend) begin
      m_rd_data = m_cap_data;
      m_rx++;
    end
    m_cap_pend = (m_act == A_RD);
    if (m_act == A_RD) begin
      m_cap_data = m_issue_data;
      m_rw = 1'b0;
    end
    if (m_act == A_WR) begin
      m_tx++;
      m_rw = 1'b1;
    end
    if (m_act == A_TURN) m_dir = !m_dir;
    m_after_turn = (m_act == A_TURN);
  endtask

  task automatic step_neg();
    @(negedge clk);
    model_eval();
  endtask

  task automatic step_pos();
    @(posedge clk);
    model_commit();
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; full = 1'b0; empty = 1'b1;
    wr_data = '0; probe_oe = 1'b0;
    fifo_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_req = 1'b1; rd_req = 1'b1; full = 1'b0; empty = 1'b0; wr_data = 8'h3C;
    probe_val = 8'hC3; probe_oe = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    tests++;
    if ({en, wr_ack, rd_ack, rd_valid, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: en/wr_ack/rd_ack/rd_valid/busy got %b want 00000",
               {en, wr_ack, rd_ack, rd_valid, busy});
    end
    tests++;
    if (rw !== 1'b1) begin
      fails++;
      $display("FAIL reset_rw: got %b want 1", rw);
    end
    tests++;
    if (rd_data !== '0 || tx_count !== '0 || rx_count !== '0) begin
      fails++;
      $display("FAIL reset_data: rd_data %h tx %0d rx %0d want 0 0 0", rd_data, tx_count, rx_count);
    end
    tests++;
    if (bus !== 8'hC3) begin
      fails++;
      $display("FAIL reset_bus_z: bus %h want %h (master must not drive)", bus, 8'hC3);
    end
    probe_oe = 1'b0;
  endtask

  task automatic test_write_burst();
    do_reset();
    wr_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = N'(i);
      step_neg();
      tests++;
      if ({wr_ack, en, rw} !== 3'b111) begin
        fails++;
        $display("FAIL burst_ack[%0d]: wr_ack/en/rw got %b want 111", i, {wr_ack, en, rw});
      end
      tests++;
      if (bus !== N'(i)) begin
        fails++;
        $display("FAIL burst_bus[%0d]: got %h want %h", i, bus, N'(i));
      end
      step_pos();
    end
    wr_req = 1'b0;
    step_neg();
    tests++;
    if (tx_count !== 16'd5 || en !== 1'b0) begin
      fails++;
      $display("FAIL burst_tx: tx %0d en %b want 5 0", tx_count, en);
    end
    step_pos();
  endtask

  task automatic test_read_after_write();
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    empty = 1'b0; rd_req = 1'b1;
    step_neg();
    tests++;
    if ({en, rd_ack, rw, busy} !== 4'b0011) begin
      fails++;
      $display("FAIL raw_turn: en/rd_ack/rw/busy got %b want 0011", {en, rd_ack, rw, busy});
    end
    step_pos();
    step_neg();
    tests++;
    if ({en, rd_ack, rw} !== 3'b110) begin
      fails++;
      $display("FAIL raw_issue: en/rd_ack/rw got %b want 110", {en, rd_ack, rw});
    end
    step_pos();
    rd_req = 1'b0; empty = 1'b1;
    step_neg();
    tests++;
    if ({rd_valid, busy, en} !== 3'b010) begin
      fails++;
      $display("FAIL raw_capture: rd_valid/busy/en got %b want 010", {rd_valid, busy, en});
    end
    step_pos();
    step_neg();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rx_count !== 16'd1) begin
      fails++;
      $display("FAIL raw_valid: valid %b data %h rx %0d want 1 a5 1", rd_valid, rd_data, rx_count);
    end
    step_pos();
    step_neg();
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL raw_hold: valid %b data %h want 0 a5", rd_valid, rd_data);
    end
    step_pos();
  endtask

  task automatic test_stall();
    int got;
    wr_req = 1'b1; full = 1'b1; wr_data = N'($urandom);
    repeat (3) begin
      step_neg();
      tests++;
      if (en !== 1'b0 || wr_ack !== 1'b0) begin
        fails++;
        $display("FAIL stall_full: en %b wr_ack %b want 0 0", en, wr_ack);
      end
      step_pos();
    end
    full = 1'b0;
    got = -1;
    for (int k = 0; k < 4 && got < 0; k++) begin
      step_neg();
      if (wr_ack === 1'b1) begin
        got = k;
        tests++;
        if (bus !== wr_data) begin
          fails++;
          $display("FAIL stall_wr_bus: got %h want %h", bus, wr_data);
        end
      end
      step_pos();
    end
    wr_req = 1'b0;
    tests++;
    if (got != 1) begin
      fails++;
      $display("FAIL stall_release: ack after %0d cycles want 1 (-1 = none in bound)", got);
    end
    rd_req = 1'b1; empty = 1'b1;
    repeat (3) begin
      step_neg();
      tests++;
      if (en !== 1'b0 || rd_ack !== 1'b0) begin
        fails++;
        $display("FAIL stall_empty: en %b rd_ack %b want 0 0", en, rd_ack);
      end
      step_pos();
    end
    rd_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(N'($urandom));
    empty = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'h5A;
    for (int k = 0; k < 12; k++) begin
      step_neg();
      tests++;
      if (rd_ack !== (k % 4 == 1) || wr_ack !== (k % 4 == 3) || busy !== 1'b1) begin
        fails++;
        $display("FAIL simul[%0d]: rd_ack %b wr_ack %b busy %b want %b %b 1",
                 k, rd_ack, wr_ack, busy, (k % 4 == 1), (k % 4 == 3));
      end
      step_pos();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) begin
      step_neg();
      step_pos();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    fifo_q.push_back(8'h96);
    empty = 1'b0; rd_req = 1'b1;
    step_neg();
    step_pos();
    step_neg();
    tests++;
    if (rd_ack !== 1'b1) begin
      fails++;
      $display("FAIL midrst_issue: rd_ack %b want 1", rd_ack);
    end
    step_pos();
    rd_req = 1'b0; empty = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({en, wr_ack, rd_ack, rd_valid, busy, rw} !== 6'b000001) begin
      fails++;
      $display("FAIL midrst_outputs: en/wr_ack/rd_ack/rd_valid/busy/rw got %b want 000001",
               {en, wr_ack, rd_ack, rd_valid, busy, rw});
    end
    tests++;
    if (rd_data !== '0 || rx_count !== '0) begin
      fails++;
      $display("FAIL midrst_data: rd_data %h rx %0d want 0 0", rd_data, rx_count);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      step_neg();
      tests++;
      if (rd_valid !== 1'b0 || rx_count !== '0) begin
        fails++;
        $display("FAIL midrst_no_valid: valid %b rx %0d want 0 0", rd_valid, rx_count);
      end
      step_pos();
    end
    fifo_q.push_back(8'h11);
    empty = 1'b0; rd_req = 1'b1;
    step_neg();
    tests++;
    if (rd_ack !== 1'b0 || en !== 1'b0) begin
      fails++;
      $display("FAIL midrst_turn: rd_ack %b en %b want 0 0", rd_ack, en);
    end
    step_pos();
    step_neg();
    tests++;
    if (rd_ack !== 1'b1) begin
      fails++;
      $display("FAIL midrst_read: rd_ack %b want 1", rd_ack);
    end
    step_pos();
    rd_req = 1'b0; empty = 1'b1;
    step_neg();
    step_pos();
    step_neg();
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin
      fails++;
      $display("FAIL midrst_after: valid %b data %h want 1 11", rd_valid, rd_data);
    end
    step_pos();
  endtask

  task automatic test_random();
    bit e_en, e_rw, e_busy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (m_act == A_WR || !wr_req) wr_data = N'($urandom);
      if ($urandom_range(0, 3) == 0) wr_req = ~wr_req;
      if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
      full  = (fifo_q.size() >= 16) || ($urandom_range(0, 4) == 0);
      empty = (fifo_q.size() == 0) || ($urandom_range(0, 5) == 0);
      step_neg();
      e_en   = (m_act == A_WR) || (m_act == A_RD);
      e_rw   = (m_act == A_WR) ? 1'b1 : (m_act == A_RD) ? 1'b0 : m_rw;
      e_busy = (m_act != A_IDLE) || m_cap_pend;
      tests++;
      if (en !== e_en || rw !== e_rw) begin
        fails++;
        $display("FAIL rand_bus_ctrl[%0d]: en/rw got %b%b want %b%b", c, en, rw, e_en, e_rw);
      end
      tests++;
      if (wr_ack !== (m_act == A_WR) || rd_ack !== (m_act == A_RD)) begin
        fails++;
        $display("FAIL rand_ack[%0d]: wr/rd ack got %b%b want %b%b", c, wr_ack, rd_ack,
                 (m_act == A_WR), (m_act == A_RD));
      end
      tests++;
      if (busy !== e_busy) begin
        fails++;
        $display("FAIL rand_busy[%0d]: got %b want %b", c, busy, e_busy);
      end
      tests++;
      if (rd_valid !== m_valid || rd_data !== m_rd_data) begin
        fails++;
        $display("FAIL rand_rd[%0d]: valid %b data %h want %b %h", c, rd_valid, rd_data, m_valid, m_rd_data);
      end
      tests++;
      if (tx_count !== CW'(m_tx) || rx_count !== CW'(m_rx)) begin
        fails++;
        $display("FAIL rand_count[%0d]: tx %0d rx %0d want %0d %0d", c, tx_count, rx_count, m_tx, m_rx);
      end
      if (m_act == A_WR) begin
        tests++;
        if (bus !== wr_data) begin
          fails++;
          $display("FAIL rand_wr_bus[%0d]: got %h want %h", c, bus, wr_data);
        end
      end
      step_pos();
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_tx_wrap();
    do_reset();
    wr_data = 8'h77; wr_req = 1'b1;
    repeat (65535) @(posedge clk);
    #2 wr_req = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_count !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_pre: tx %0d want 65535", tx_count);
    end
    @(posedge clk);
    #2 wr_req = 1'b1;
    @(negedge clk);
    tests++;
    if (wr_ack !== 1'b1) begin
      fails++;
      $display("FAIL wrap_ack: wr_ack %b want 1", wr_ack);
    end
    @(posedge clk);
    #2 wr_req = 1'b0;
    @(negedge clk);
    tests++;
    if (tx_count !== '0) begin
      fails++;
      $display("FAIL wrap_zero: tx %0d want 0", tx_count);
    end
    fifo_q.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_burst();
    test_read_after_write();
    test_stall();
    test_simultaneous();
    test_reset_mid_read();
    test_random();
    test_tx_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
